// File: rtl/nic_traffic_gen_if.sv
// rtl/nic_traffic_gen_if.sv - NIC register-port bus between a traffic generator and its node's NIC
interface nic_traffic_gen_if;
   logic        nicEn;
   logic        nicWrEn;
   logic [1:0]  addr_nic;
   logic [0:63] din_nic;
   logic [0:63] dout_nic;

   modport master (output nicEn, nicWrEn, addr_nic, din_nic, input dout_nic);
   modport slave  (input nicEn, nicWrEn, addr_nic, din_nic, output dout_nic);
endinterface

// File: rtl/nic_traffic_gen.sv
// rtl/nic_traffic_gen.sv - CPU stand-in that polls a NIC, injects sequenced packets and checks received ones
module nic_traffic_gen #(
   parameter logic [15:0] NODE_ID  = 16'd0,
   parameter logic [15:0] EXP_SRC  = 16'd1,
   parameter bit          DIR      = 1'b0,
   parameter logic [7:0]  HOP      = 8'h01,
   parameter int          NUM_PKTS = 16,
   parameter int          NUM_RECV = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               start,
   nic_traffic_gen_if.master  bus,
   output logic               done,
   output logic               err,
   output logic [15:0]        sent_cnt,
   output logic [15:0]        recv_cnt
);
   localparam logic [15:0] NP = NUM_PKTS[15:0];
   localparam logic [15:0] NR = NUM_RECV[15:0];
   localparam logic [1:0] A_RXBUF = 2'b00;
   localparam logic [1:0] A_RXST  = 2'b01;
   localparam logic [1:0] A_TXBUF = 2'b10;
   localparam logic [1:0] A_TXST  = 2'b11;

   typedef enum logic [2:0] {IDLE, CHK_TX, SEND, CHK_RX, RECV, DONE} state_t;
   state_t state, next_state;

   logic        full, go, rx_bad, tx_left, rx_left;
   logic        nxt_en, nxt_wr;
   logic [1:0]  nxt_addr;
   logic [0:63] nxt_din;
   logic        unused_hdr;

   // Counters only ever step while below their limit, so inequality is the same as "less than".
   assign tx_left    = (sent_cnt != NP);
   assign rx_left    = (recv_cnt != NR);
   assign full       = bus.dout_nic[63];
   assign go         = start && (state == IDLE || state == DONE);
   assign rx_bad     = (bus.dout_nic[32:47] != EXP_SRC) || (bus.dout_nic[48:63] != recv_cnt);
   assign unused_hdr = ^bus.dout_nic[0:31];

   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: if (start) next_state = CHK_TX;
         CHK_TX:     next_state = (!full && tx_left) ? SEND : CHK_RX;
         SEND:       next_state = CHK_RX;
         CHK_RX: begin
            if (full && rx_left)              next_state = RECV;
            else if (!tx_left && !rx_left)    next_state = DONE;
            else                              next_state = CHK_TX;
         end
         RECV:       next_state = CHK_TX;
         default:    next_state = IDLE;
      endcase
   end

   // Decoded from next_state so the registered bus outputs line up with the state they belong to.
   always_comb begin
      nxt_en   = 1'b0;
      nxt_wr   = 1'b0;
      nxt_addr = A_RXBUF;
      nxt_din  = '0;
      case (next_state)
         CHK_TX: begin
            nxt_en   = 1'b1;
            nxt_addr = A_TXST;
         end
         SEND: begin
            nxt_en   = 1'b1;
            nxt_wr   = 1'b1;
            nxt_addr = A_TXBUF;
            nxt_din  = {sent_cnt[15], DIR, 6'b0, HOP, 16'b0, NODE_ID, sent_cnt};
         end
         CHK_RX: begin
            nxt_en   = 1'b1;
            nxt_addr = A_RXST;
         end
         RECV: begin
            nxt_en   = 1'b1;
            nxt_addr = A_RXBUF;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         bus.nicEn    <= 1'b0;
         bus.nicWrEn  <= 1'b0;
         bus.addr_nic <= A_RXBUF;
         bus.din_nic  <= '0;
         done         <= 1'b0;
         err          <= 1'b0;
         sent_cnt     <= 16'd0;
         recv_cnt     <= 16'd0;
      end else begin
         bus.nicEn    <= nxt_en;
         bus.nicWrEn  <= nxt_wr;
         bus.addr_nic <= nxt_addr;
         bus.din_nic  <= nxt_din;
         done         <= (next_state == DONE);
         if (go) begin
            err      <= 1'b0;
            sent_cnt <= 16'd0;
            recv_cnt <= 16'd0;
         end else begin
            if (state == SEND) sent_cnt <= sent_cnt + 16'd1;
            if (state == RECV) begin
               if (rx_bad) err <= 1'b1;
               recv_cnt <= recv_cnt + 16'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_nic_traffic_gen.sv
// tb/tb_nic_traffic_gen.sv - randomized bench for nic_traffic_gen against a behavioural NIC and scoreboard
module tb_nic_traffic_gen;
   localparam logic [15:0] NODE_ID = 16'h0005;
   localparam logic [15:0] EXP_SRC = 16'h0003;
   localparam bit          DIR     = 1'b1;
   localparam logic [7:0]  HOP     = 8'h2a;
   localparam int          NP      = 6;
   localparam int          NR      = 5;

   logic        CLK = 1'b0, RESET = 1'b1, start = 1'b0, start0 = 1'b0;
   logic        done, err, done0, err0;
   logic [15:0] sent_cnt, recv_cnt, sent0, recv0;
   int          n_vec = 0, n_bad = 0;

   always #5 CLK = ~CLK;

   nic_traffic_gen_if bus();
   nic_traffic_gen_if bus0();

   nic_traffic_gen #(.NODE_ID(NODE_ID), .EXP_SRC(EXP_SRC), .DIR(DIR), .HOP(HOP),
                     .NUM_PKTS(NP), .NUM_RECV(NR)) dut (
      .CLK(CLK), .RESET(RESET), .start(start), .bus(bus),
      .done(done), .err(err), .sent_cnt(sent_cnt), .recv_cnt(recv_cnt));

   nic_traffic_gen #(.NUM_PKTS(0), .NUM_RECV(0)) dut0 (
      .CLK(CLK), .RESET(RESET), .start(start0), .bus(bus0),
      .done(done0), .err(err0), .sent_cnt(sent0), .recv_cnt(recv0));

   // Zero-count instance: tx never full, rx always reports full.
   assign bus0.dout_nic = (bus0.addr_nic == 2'b01) ? 64'd1 : 64'd0;

   // Behavioural NIC: rx FIFO in an array, tx writes logged in order.
   logic [0:63] rx_mem [0:255];
   logic [0:63] tx_log [0:255];
   int   rx_rd = 0, rx_wr = 0, tx_n = 0, proto_err = 0;
   int   tx_mode = 0, rx_mode = 0;
   logic tx_full = 1'b0, rx_full = 1'b0;
   bit   rx_flush = 1'b0;

   always @(negedge CLK) begin
      tx_full = (tx_mode == 2) || (tx_mode == 1 && $urandom_range(0, 2) == 0);
      rx_full = (rx_rd < rx_wr) && (rx_mode == 0 || $urandom_range(0, 1) == 1);
   end

   always_comb begin
      case (bus.addr_nic)
         2'b00:   bus.dout_nic = rx_mem[rx_rd[7:0]];
         2'b01:   bus.dout_nic = {63'b0, rx_full};
         2'b11:   bus.dout_nic = {63'b0, tx_full};
         default: bus.dout_nic = '0;
      endcase
   end

   always @(posedge CLK) begin
      if (rx_flush) rx_rd <= rx_wr;
      else if (!RESET && bus.nicEn) begin
         if (bus.nicWrEn) begin
            if (bus.addr_nic != 2'b10) proto_err <= proto_err + 1;
            tx_log[tx_n[7:0]] <= bus.din_nic;
            tx_n <= tx_n + 1;
         end else if (bus.addr_nic == 2'b00) begin
            if (rx_rd >= rx_wr) proto_err <= proto_err + 1;
            rx_rd <= rx_rd + 1;
         end
      end
   end

   function automatic logic [63:0] tx_pkt(input int seq);
      tx_pkt = (64'(seq[15]) << 63) | (64'(DIR) << 62) | (64'(HOP) << 48)
             | (64'(NODE_ID) << 16) | 64'(seq[15:0]);
   endfunction

   function automatic logic [63:0] rx_pkt(input logic [15:0] src, input logic [15:0] seq);
      logic [31:0] r;
      r = $urandom;
      rx_pkt = {r, src, seq};
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic flush_rx;
      rx_flush = 1'b1;
      @(negedge CLK);
      rx_flush = 1'b0;
   endtask

   task automatic load_rx(input int bad, input int extra, input bit bad_src);
      logic [15:0] s, q;
      for (int i = 0; i < NR + extra; i++) begin
         s = EXP_SRC;
         q = 16'(i);
         if (i == bad) begin
            if (bad_src) s = EXP_SRC ^ 16'h0100;
            else         q = 16'(i + 1);
         end
         rx_mem[(rx_wr + i) % 256] = rx_pkt(s, q);
      end
      rx_wr = rx_wr + NR + extra;
   endtask

   task automatic finish_run(input bit exp_err, input int rxb, input int txb, input string tag);
      int cyc;
      cyc = 0;
      while (!done && cyc < 3000) begin
         @(negedge CLK);
         cyc++;
      end
      check_eq({tag, "_done"}, 64'(done), 64'd1);
      check_eq({tag, "_err"}, 64'(err), 64'(exp_err));
      check_eq({tag, "_sent_cnt"}, 64'(sent_cnt), 64'(NP));
      check_eq({tag, "_recv_cnt"}, 64'(recv_cnt), 64'(NR));
      check_eq({tag, "_tx_writes"}, 64'(tx_n - txb), 64'(NP));
      check_eq({tag, "_rx_reads"}, 64'(rx_rd - rxb), 64'(NR));
      check_eq({tag, "_protocol"}, 64'(proto_err), 64'd0);
      for (int i = 0; i < NP; i++)
         check_eq({tag, "_pkt"}, tx_log[(txb + i) % 256], tx_pkt(i));
      flush_rx();
   endtask

   initial begin
      int rxb, txb, cyc, alt_bad, prev_addr, bad, extra;
      bit bsrc;

      RESET = 1'b1;
      tick(3);
      check_eq("rst_nicEn", 64'(bus.nicEn), 64'd0);
      check_eq("rst_nicWrEn", 64'(bus.nicWrEn), 64'd0);
      check_eq("rst_addr", 64'(bus.addr_nic), 64'd0);
      check_eq("rst_din", bus.din_nic, 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_err", 64'(err), 64'd0);
      check_eq("rst_sent", 64'(sent_cnt), 64'd0);
      check_eq("rst_recv", 64'(recv_cnt), 64'd0);
      RESET = 1'b0;
      tick(2);
      check_eq("idle_nicEn", 64'(bus.nicEn), 64'd0);

      // NUM_PKTS=0, NUM_RECV=0: CHK_TX, CHK_RX, DONE with no write and no rx read.
      start0 = 1'b1;
      tick(1);
      start0 = 1'b0;
      check_eq("zero_chk_tx", {62'd0, bus0.nicEn, bus0.addr_nic == 2'b11}, 64'd3);
      tick(1);
      check_eq("zero_chk_rx", {61'd0, bus0.nicEn, bus0.addr_nic}, 64'd5);
      tick(1);
      check_eq("zero_done", {62'd0, done0, bus0.nicEn}, 64'd2);
      tick(3);
      check_eq("zero_held", {30'd0, done0, err0, sent0, recv0}, 64'h2_0000_0000);

      // Tx status held full: only status polls, strictly alternating.
      tx_mode = 2;
      rx_mode = 0;
      rxb = rx_rd;
      txb = tx_n;
      pulse_start();
      alt_bad = 0;
      prev_addr = -1;
      for (int i = 0; i < 20; i++) begin
         if (bus.nicWrEn || !bus.nicEn || int'(bus.addr_nic) == prev_addr ||
             bus.addr_nic == 2'b00 || bus.addr_nic == 2'b10) alt_bad++;
         prev_addr = int'(bus.addr_nic);
         tick(1);
      end
      check_eq("full_alternate", 64'(alt_bad), 64'd0);
      check_eq("full_no_write", 64'(tx_n - txb), 64'd0);
      tx_mode = 0;
      cyc = 0;
      while (!bus.nicWrEn && cyc < 5) begin
         tick(1);
         cyc++;
      end
      check_eq("send_after_release", 64'(bus.nicWrEn), 64'd1);
      load_rx(-1, 0, 1'b0);
      finish_run(1'b0, rxb, txb, "release");

      // Randomized runs; the first is the directed seq 0,2,... gap case.
      tx_mode = 1;
      rx_mode = 1;
      for (int r = 0; r < 6; r++) begin
         extra = $urandom_range(0, 2);
         if (r == 0) begin
            bad = 1;
            bsrc = 1'b0;
         end else begin
            bad = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, NR + extra - 1));
            bsrc = 1'($urandom_range(0, 1));
         end
         rxb = rx_rd;
         txb = tx_n;
         load_rx(bad, extra, bsrc);
         pulse_start();
         if (r == 0) begin
            cyc = 0;
            while (recv_cnt < 16'd2 && cyc < 1000) begin
               tick(1);
               cyc++;
            end
            check_eq("gap_err_after_2nd", {63'd0, err}, 64'd1);
         end
         finish_run(bad >= 0 && bad < NR, rxb, txb, "rand");
      end

      // RESET during a SEND cycle, then a clean restart.
      tx_mode = 0;
      rx_mode = 0;
      load_rx(-1, 0, 1'b0);
      pulse_start();
      cyc = 0;
      while (!(bus.nicWrEn && sent_cnt != 16'd0) && cyc < 50) begin
         tick(1);
         cyc++;
      end
      check_eq("send_seen", 64'(bus.nicWrEn), 64'd1);
      RESET = 1'b1;
      tick(1);
      check_eq("rst_send_nicEn", {62'd0, bus.nicEn, bus.nicWrEn}, 64'd0);
      check_eq("rst_send_cnts", {30'd0, done, err, sent_cnt, recv_cnt}, 64'd0);
      RESET = 1'b0;
      flush_rx();
      rxb = rx_rd;
      txb = tx_n;
      load_rx(-1, 1, 1'b0);
      pulse_start();
      finish_run(1'b0, rxb, txb, "restart");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
